conv_accumulator: RTL
=====================

CONV_ACCUMULATOR -- requirements
Module: conv_accumulator

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the conv result input and of the accumulated output.
REQ-002 SHALL have parameter CNT_W, default 8, width of the partial-sum count.
REQ-003 SHALL have parameter ACC_W, default 40 (DATA_W+CNT_W), internal signed accumulator width.
REQ-004 SHALL use one clock and a synchronous, active-low reset; ports named clk and rst.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-007 SHALL have port start, input, 1, single-cycle pulse that begins an accumulation.
REQ-008 SHALL have port len, input, CNT_W, number of partial sums to accumulate; sampled with start.
REQ-009 SHALL have port relu_en, input, 1, apply ReLU to the final result; sampled with start.
REQ-010 SHALL have port in_valid, input, 1, in_data carries a conv partial sum.
REQ-011 SHALL have port in_data, input, DATA_W, signed two's-complement partial sum from the ALU conv path.
REQ-012 SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-013 SHALL have port out_valid, output, 1, out_data holds a finished result.
REQ-014 SHALL have port out_data, output, DATA_W, saturated and optionally rectified sum.
REQ-015 SHALL have port out_ready, input, 1, consumer takes out_data.
REQ-016 SHALL have port sat, output, 1, the current result was clipped; valid while out_valid.
REQ-017 SHALL have port busy, output, 1, high in ACCUM and DONE.
REQ-018 SHALL have port remaining, output, CNT_W, partial sums still expected.

Function
REQ-019 SHALL implement FSM states IDLE, ACCUM and DONE.
REQ-020 IDLE: in_ready=0, out_valid=0, busy=0; start=1 with len!=0 -> ACCUM next cycle, acc<=0, remaining<=len, relu_en latched, sat<=0.
REQ-021 IDLE: start=1 with len==0 SHALL be ignored; the block stays in IDLE.
REQ-022 ACCUM: in_ready=1; a beat is accepted when in_valid&&in_ready; acc<=acc+sign-extended in_data; remaining<=remaining-1.
REQ-023 ACCUM: a beat accepted while remaining==1 -> DONE next cycle; out_data and sat SHALL be registered from acc+in_data in that same edge.
REQ-024 Latency: out_valid SHALL rise exactly one cycle after the final beat is accepted.
REQ-025 The ACC_W sum SHALL never wrap; saturation applies only at output: >2^(DATA_W-1)-1 -> 0x7FFFFFFF, <-2^(DATA_W-1) -> 0x80000000, sat=1; otherwise the exact value with sat=0.
REQ-026 ReLU SHALL apply after saturation: if the latched relu_en=1 and the saturated value is negative, out_data=0; sat keeps its saturation value.
REQ-027 DONE: out_valid=1, in_ready=0; out_data and sat SHALL hold stable until out_valid&&out_ready, then -> IDLE next cycle with out_valid=0.
REQ-028 start SHALL be ignored in ACCUM and DONE; len and relu_en SHALL be sampled only on an accepted start.
REQ-029 in_valid SHALL be ignored outside ACCUM; ACCUM waits indefinitely for in_valid with no timeout.
REQ-030 DONE with out_ready=1 and start=1 in the same cycle SHALL return to IDLE only; that start is dropped.

Reset
REQ-031 With rst=0 at a rising edge: state=IDLE, acc=0, remaining=0, out_data=0, out_valid=0, sat=0, in_ready=0, busy=0, latched relu_en=0.
REQ-032 Reset in ACCUM or DONE SHALL abandon the operation with no output; out_valid is 0 on the cycle after reset.

Verification
REQ-033 len=3, relu_en=0, beats 10, -4, 7 back-to-back -> out_valid one cycle after third beat, out_data=13, sat=0.
REQ-034 len=2, beats 0x7FFFFFFF, 0x00000005 -> out_data=0x7FFFFFFF, sat=1; len=2, beats 0x80000000, 0xFFFFFFFF -> out_data=0x80000000, sat=1.
REQ-035 len=2, relu_en=1, beats -20, 5 -> out_data=0, sat=0; same with relu_en=0 -> out_data=0xFFFFFFF1.
REQ-036 len=4 with in_valid gaps, then out_ready held low 5 cycles -> out_data stable, in_ready=0, start pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-037 start with len=0 -> busy stays 0; rst=0 after 2 of 3 beats -> out_valid never asserts, all outputs 0 after reset.

Source files
------------

// File: rtl/conv_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : conv_accumulator
//  Purpose  : Sums a run of signed conv partial sums. The sum is kept in a
//             wide accumulator so it never wraps. The result is saturated to
//             DATA_W and can optionally be rectified (ReLU). It is then held
//             on a valid/ready output port.
//  Ports    : clk, rst (sync, active-low)
//             start, len, relu_en        - operation request (IDLE only)
//             in_valid, in_data, in_ready- partial-sum input stream
//             out_valid, out_data, sat,
//             out_ready                  - result handshake
//             busy, remaining            - status
//  Revision : 1.0 - initial release
// ============================================================================
module conv_accumulator #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8,
    parameter int ACC_W  = DATA_W + CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              relu_en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              sat,
    output logic              busy,
    output logic [CNT_W-1:0]  remaining
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    state_t              state_q,    state_d;
    logic [ACC_W-1:0]    acc_q,      acc_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic                relu_q,     relu_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                sat_q,      sat_d;

    logic [ACC_W-1:0]    w_in_ext;
    logic [ACC_W-1:0]    w_sum;
    logic [ACC_W-DATA_W:0] w_sum_hi;
    logic                w_overflow;
    logic [DATA_W-1:0]   w_sat_val;
    logic [DATA_W-1:0]   w_final_val;

    // Running sum including the beat currently presented on in_data.
    assign w_in_ext = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
    assign w_sum    = acc_q + w_in_ext;

    // The value fits in DATA_W exactly when every bit from the DATA_W sign
    // position upward is a copy of the accumulator sign bit.
    assign w_sum_hi    = w_sum[ACC_W-1:DATA_W-1];
    assign w_overflow  = !((&w_sum_hi) || (~|w_sum_hi));
    assign w_sat_val   = w_overflow ? (w_sum[ACC_W-1] ? SAT_MIN : SAT_MAX)
                                    : w_sum[DATA_W-1:0];
    // ReLU acts on the saturated value; sat still reports the clipping.
    assign w_final_val = (relu_q && w_sat_val[DATA_W-1]) ? '0 : w_sat_val;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        remaining_d = remaining_q;
        relu_d      = relu_q;
        out_data_d  = out_data_q;
        sat_d       = sat_q;

        case (state_q)
            S_IDLE: begin
                // A zero-length request has nothing to produce and is dropped.
                if (start && (len != '0)) begin
                    state_d     = S_ACCUM;
                    acc_d       = '0;
                    remaining_d = len;
                    relu_d      = relu_en;
                    sat_d       = 1'b0;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    acc_d       = w_sum;
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d    = S_DONE;
                        out_data_d = w_final_val;
                        sat_d      = w_overflow;
                    end
                end
            end
            S_DONE: begin
                // A start arriving with the handshake is intentionally lost.
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            remaining_q <= '0;
            relu_q      <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            remaining_q <= remaining_d;
            relu_q      <= relu_d;
            out_data_q  <= out_data_d;
            sat_q       <= sat_d;
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_data  = out_data_q;
    assign sat       = sat_q;
    assign remaining = remaining_q;

endmodule
`default_nettype wire
